thread_issue_scheduler: RTL and testbench
=========================================

Name: thread_issue_scheduler

Overview:
- Round-robin barrel-thread issue scheduler placed in front of the Datapath.
- Holds one pending instruction per thread and presents it to the Datapath in that thread's fixed slot: control, read_addr_A, read_addr_B, write_addr_D, split and branch_cancel.
- Tracks each issued instruction until the Datapath's IO_ready result returns. Retires the instruction when IO_ready=1; otherwise re-issues it in the thread's next slot.

Parameters:
- THREAD_COUNT, 8: number of threads and slots; power of two.
- THREAD_WIDTH, 3: log2(THREAD_COUNT).
- CTRL_WIDTH, 20: Datapath control word width; MSB is split.
- READ_ADDR_WIDTH, 10: A/B read address width.
- WRITE_ADDR_WIDTH, 12: D write address width.
- NOP_CTRL, 0: control value driven when a slot is empty.
- IO_READY_LATENCY, 3: cycles from an issue appearing on the outputs to its IO_ready sample. Legal range 0..THREAD_COUNT-2.
- RETRY_COUNT_WIDTH, 16: width of the retry counter.

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  load request
- in_thread  in  THREAD_WIDTH  target thread of the load
- in_control  in  CTRL_WIDTH  instruction control word
- in_read_addr_A  in  READ_ADDR_WIDTH  A read address
- in_read_addr_B  in  READ_ADDR_WIDTH  B read address
- in_write_addr_D  in  WRITE_ADDR_WIDTH  D write address
- in_ready  out  1  combinational: entry[in_thread] is EMPTY
- IO_ready  in  1  Datapath IO result for the issue made IO_READY_LATENCY cycles earlier
- control  out  CTRL_WIDTH  to Datapath
- split  out  1  control[CTRL_WIDTH-1]
- branch_cancel  out  1  1 = slot empty or annulled
- read_addr_A  out  READ_ADDR_WIDTH  to Datapath
- read_addr_B  out  READ_ADDR_WIDTH  to Datapath
- write_addr_D  out  WRITE_ADDR_WIDTH  to Datapath
- issue_valid  out  1  real instruction on the outputs this cycle
- issue_thread  out  THREAD_WIDTH  thread owning the current outputs
- retry_count  out  RETRY_COUNT_WIDTH  saturating count of IO_ready=0 results

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - slot counter = 0; all entries EMPTY; tag pipeline cleared.
  - control = NOP_CTRL; split = NOP_CTRL[MSB]; branch_cancel = 1; issue_valid = 0.
  - all address outputs = 0; issue_thread = 0; retry_count = 0.
  - In-flight results are discarded; a reset in mid-operation loses all held instructions.
- Slot counter increments every cycle and wraps from THREAD_COUNT-1 to 0. It never stalls.
- Per-thread entry states: EMPTY, PENDING, IN_FLIGHT.
  - EMPTY -> PENDING: in_valid=1 and in_ready=1 at a clock edge. The fields are captured.
  - PENDING -> IN_FLIGHT: slot counter equals the thread at a clock edge.
  - IN_FLIGHT -> EMPTY: IO_ready=1 when that thread's tag reaches the pipeline end.
  - IN_FLIGHT -> PENDING: IO_ready=0 at that point; retry_count increments and holds at all-ones.
- A load with in_ready=0 is ignored; the upstream block holds in_valid.
- Issue timing: thread s selected in cycle t drives the outputs in cycle t+1 (registered, one-cycle latency).
  - issue_thread = s in every cycle, including empty slots.
  - PENDING entry: entry fields on the outputs, issue_valid = 1, branch_cancel = 0.
  - Otherwise: NOP_CTRL on control, addresses held at their previous values, issue_valid = 0, branch_cancel = 1.
- Result timing: IO_ready in cycle t+1+IO_READY_LATENCY belongs to the issue made in cycle t+1. IO_ready is ignored when that tag's valid bit is 0.
  - The state update is visible at t+2+IO_READY_LATENCY, which is at or before t+THREAD_COUNT. A retry therefore re-issues in the very next slot of the same thread.
  - Re-issue output fields are bit-identical to the original issue.
- Same-cycle retire and load for one thread: in_ready reflects the pre-edge state (IN_FLIGHT = 0), so the load is refused that cycle and accepted in a later one.
- Loads and retires for different threads in the same cycle are independent.
- Entries are never issued out of slot order; there is no priority between threads.

Test Plan:
- Reset: reset_n=0 for 3 cycles, then release; no loads -> every cycle branch_cancel=1, issue_valid=0, control=0, and issue_thread counts 0,1,..,7,0.
- Single issue: load thread 2 with control=0x00005, A=2, B=3, D=4; IO_READY_LATENCY=3; IO_ready tied to 1 -> one issue with issue_thread=2 and those fields; entry returns to EMPTY; in_ready for thread 2 is 1 before its next slot; retry_count=0.
- Retry: as the single-issue case, but IO_ready=0 on the first result and 1 on the second -> thread 2 issued twice, exactly 8 cycles apart, with identical fields; retry_count=1.
- All threads: load threads 0..7 back-to-back; IO_ready always 1 -> 8 consecutive cycles with issue_valid=1 and issue_thread 0..7; all entries end EMPTY.
- Conflict: attempt a load to thread 5 in the same cycle its result returns with IO_ready=1 -> load refused (in_ready=0); accepted the next cycle; issued in the following thread-5 slot.
- Mid-flight reset: assert reset_n=0 while threads 1 and 3 are IN_FLIGHT -> outputs return to reset values immediately; after release no issue occurs and a later IO_ready is ignored; retry_count=0.

Source files
------------

// File: rtl/thread_issue_scheduler_if.sv
// Load and Datapath issue signals of the barrel-thread issue scheduler.
// The slave side is the scheduler; the master side is its environment
// (upstream loader plus the Datapath returning IO_ready).
interface thread_issue_scheduler_if #(
  parameter int THREAD_WIDTH      = 3,
  parameter int CTRL_WIDTH        = 20,
  parameter int READ_ADDR_WIDTH   = 10,
  parameter int WRITE_ADDR_WIDTH  = 12,
  parameter int RETRY_COUNT_WIDTH = 16
);
  // Load side
  logic                          in_valid;
  logic [THREAD_WIDTH-1:0]       in_thread;
  logic [CTRL_WIDTH-1:0]         in_control;
  logic [READ_ADDR_WIDTH-1:0]    in_read_addr_A;
  logic [READ_ADDR_WIDTH-1:0]    in_read_addr_B;
  logic [WRITE_ADDR_WIDTH-1:0]   in_write_addr_D;
  logic                          in_ready;

  // Datapath side
  logic                          IO_ready;
  logic [CTRL_WIDTH-1:0]         control;
  logic                          split;
  logic                          branch_cancel;
  logic [READ_ADDR_WIDTH-1:0]    read_addr_A;
  logic [READ_ADDR_WIDTH-1:0]    read_addr_B;
  logic [WRITE_ADDR_WIDTH-1:0]   write_addr_D;
  logic                          issue_valid;
  logic [THREAD_WIDTH-1:0]       issue_thread;
  logic [RETRY_COUNT_WIDTH-1:0]  retry_count;

  modport master (
    output in_valid, in_thread, in_control, in_read_addr_A, in_read_addr_B,
           in_write_addr_D, IO_ready,
    input  in_ready, control, split, branch_cancel, read_addr_A, read_addr_B,
           write_addr_D, issue_valid, issue_thread, retry_count
  );

  modport slave (
    input  in_valid, in_thread, in_control, in_read_addr_A, in_read_addr_B,
           in_write_addr_D, IO_ready,
    output in_ready, control, split, branch_cancel, read_addr_A, read_addr_B,
           write_addr_D, issue_valid, issue_thread, retry_count
  );
endinterface

// File: rtl/thread_issue_scheduler.sv
// Round-robin barrel-thread issue scheduler. Each thread owns one entry
// (EMPTY / PENDING / IN_FLIGHT) and one fixed slot of a free-running slot
// counter. A PENDING entry is issued in its slot; the issue's tag travels
// down a pipeline matched to the Datapath IO latency, and the returning
// IO_ready either retires the entry or puts it back to PENDING for a
// bit-identical re-issue in the thread's next slot.
module thread_issue_scheduler #(
  parameter int                    THREAD_COUNT      = 8,
  parameter int                    THREAD_WIDTH      = 3,
  parameter int                    CTRL_WIDTH        = 20,
  parameter int                    READ_ADDR_WIDTH   = 10,
  parameter int                    WRITE_ADDR_WIDTH  = 12,
  parameter logic [CTRL_WIDTH-1:0] NOP_CTRL          = '0,
  parameter int                    IO_READY_LATENCY  = 3,
  parameter int                    RETRY_COUNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  thread_issue_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_IN_FLIGHT
  } entry_state_e;

  entry_state_e                  state_q [THREAD_COUNT];
  entry_state_e                  state_d [THREAD_COUNT];

  logic [CTRL_WIDTH-1:0]         ctrl_mem_q [THREAD_COUNT];
  logic [READ_ADDR_WIDTH-1:0]    addr_a_mem_q [THREAD_COUNT];
  logic [READ_ADDR_WIDTH-1:0]    addr_b_mem_q [THREAD_COUNT];
  logic [WRITE_ADDR_WIDTH-1:0]   addr_d_mem_q [THREAD_COUNT];

  logic [THREAD_WIDTH-1:0]       slot_q;
  logic [CTRL_WIDTH-1:0]         control_q;
  logic [READ_ADDR_WIDTH-1:0]    addr_a_q;
  logic [READ_ADDR_WIDTH-1:0]    addr_b_q;
  logic [WRITE_ADDR_WIDTH-1:0]   addr_d_q;
  logic                          issue_valid_q;
  logic [THREAD_WIDTH-1:0]       issue_thread_q;
  logic [RETRY_COUNT_WIDTH-1:0]  retry_q;
  logic [RETRY_COUNT_WIDTH-1:0]  retry_d;

  logic                          in_ready;
  logic                          load_accept;
  logic                          issue_now;
  logic                          res_valid;
  logic [THREAD_WIDTH-1:0]       res_thread;

  // A load is only taken into an EMPTY entry; the pre-edge state decides,
  // so a thread retiring this very cycle refuses the load until next cycle.
  assign in_ready    = (state_q[bus.in_thread] == ST_EMPTY);
  assign load_accept = bus.in_valid && in_ready;
  assign issue_now   = (state_q[slot_q] == ST_PENDING);

  // Capture the instruction fields of an accepted load.
  // NOTE: payload storage has no reset; an entry's state, not its data,
  // says whether it holds anything, so reset only needs to clear states.
  always_ff @(posedge clock) begin
    if (load_accept) begin
      ctrl_mem_q[bus.in_thread]   <= bus.in_control;
      addr_a_mem_q[bus.in_thread] <= bus.in_read_addr_A;
      addr_b_mem_q[bus.in_thread] <= bus.in_read_addr_B;
      addr_d_mem_q[bus.in_thread] <= bus.in_write_addr_D;
    end
  end

  // Free-running slot counter and the registered issue outputs.
  // NOTE: every sequential assignment is non-blocking so all registers
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_q         <= '0;
      control_q      <= NOP_CTRL;
      addr_a_q       <= '0;
      addr_b_q       <= '0;
      addr_d_q       <= '0;
      issue_valid_q  <= 1'b0;
      issue_thread_q <= '0;
    end else begin
      slot_q         <= slot_q + THREAD_WIDTH'(1);
      issue_thread_q <= slot_q;
      issue_valid_q  <= issue_now;
      if (issue_now) begin
        control_q <= ctrl_mem_q[slot_q];
        addr_a_q  <= addr_a_mem_q[slot_q];
        addr_b_q  <= addr_b_mem_q[slot_q];
        addr_d_q  <= addr_d_mem_q[slot_q];
      end else begin
        control_q <= NOP_CTRL;
      end
    end
  end

  // Tag pipeline: aligns each issue with the IO_ready that answers it.
  if (IO_READY_LATENCY == 0) begin : g_no_pipe
    assign res_valid  = issue_valid_q;
    assign res_thread = issue_thread_q;
  end else begin : g_pipe
    logic                    pipe_valid_q  [IO_READY_LATENCY];
    logic [THREAD_WIDTH-1:0] pipe_thread_q [IO_READY_LATENCY];

    // Shift the issue tag one stage per cycle; reset drops in-flight tags.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < IO_READY_LATENCY; k++) begin
          pipe_valid_q[k]  <= 1'b0;
          pipe_thread_q[k] <= '0;
        end
      end else begin
        pipe_valid_q[0]  <= issue_valid_q;
        pipe_thread_q[0] <= issue_thread_q;
        for (int k = 1; k < IO_READY_LATENCY; k++) begin
          pipe_valid_q[k]  <= pipe_valid_q[k-1];
          pipe_thread_q[k] <= pipe_thread_q[k-1];
        end
      end
    end

    assign res_valid  = pipe_valid_q[IO_READY_LATENCY-1];
    assign res_thread = pipe_thread_q[IO_READY_LATENCY-1];
  end

  // Entry next-state: load, issue and result touch disjoint states, so at
  // most one of them can apply to any given thread in a cycle.
  // NOTE: defaults come first so every path assigns every variable and no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (load_accept) begin
      state_d[bus.in_thread] = ST_PENDING;
    end
    if (issue_now) begin
      state_d[slot_q] = ST_IN_FLIGHT;
    end
    if (res_valid && (state_q[res_thread] == ST_IN_FLIGHT)) begin
      if (bus.IO_ready) begin
        state_d[res_thread] = ST_EMPTY;
      end else begin
        state_d[res_thread] = ST_PENDING;
        if (retry_q != '1) begin
          retry_d = retry_q + RETRY_COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Entry state and retry counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int t = 0; t < THREAD_COUNT; t++) begin
        state_q[t] <= ST_EMPTY;
      end
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.control       = control_q;
  assign bus.split         = control_q[CTRL_WIDTH-1];
  assign bus.branch_cancel = !issue_valid_q;
  assign bus.read_addr_A   = addr_a_q;
  assign bus.read_addr_B   = addr_b_q;
  assign bus.write_addr_D  = addr_d_q;
  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_thread  = issue_thread_q;
  assign bus.retry_count   = retry_q;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Directed bench for thread_issue_scheduler: a per-cycle vector table for
// the single-issue / retry flow plus hand-written reset, all-thread,
// load-conflict and mid-flight-reset sequences.
module tb_thread_issue_scheduler;

  localparam int TC  = 8;
  localparam int TW  = 3;
  localparam int CW  = 20;
  localparam int RAW = 10;
  localparam int WAW = 12;
  localparam int LAT = 3;
  localparam int RCW = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 clock = ~clock;

  thread_issue_scheduler_if #(
    .THREAD_WIDTH(TW), .CTRL_WIDTH(CW), .READ_ADDR_WIDTH(RAW),
    .WRITE_ADDR_WIDTH(WAW), .RETRY_COUNT_WIDTH(RCW)
  ) bus ();

  thread_issue_scheduler #(
    .THREAD_COUNT(TC), .THREAD_WIDTH(TW), .CTRL_WIDTH(CW),
    .READ_ADDR_WIDTH(RAW), .WRITE_ADDR_WIDTH(WAW), .NOP_CTRL('0),
    .IO_READY_LATENCY(LAT), .RETRY_COUNT_WIDTH(RCW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic           ld;
    logic [TW-1:0]  th;
    logic           io;
    logic           exp_rdy;
    logic           exp_v;
    logic [TW-1:0]  exp_th;
    logic [CW-1:0]  exp_ctl;
    logic [RAW-1:0] exp_a;
    logic [RAW-1:0] exp_b;
    logic [WAW-1:0] exp_d;
    logic [RCW-1:0] exp_retry;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.in_valid        = 1'b0;
    bus.in_thread       = '0;
    bus.in_control      = '0;
    bus.in_read_addr_A  = '0;
    bus.in_read_addr_B  = '0;
    bus.in_write_addr_D = '0;
  endtask

  task automatic drive_load(input logic [TW-1:0] th, input logic [CW-1:0] ctl,
                            input logic [RAW-1:0] a, input logic [RAW-1:0] b,
                            input logic [WAW-1:0] d);
    bus.in_valid        = 1'b1;
    bus.in_thread       = th;
    bus.in_control      = ctl;
    bus.in_read_addr_A  = a;
    bus.in_read_addr_B  = b;
    bus.in_write_addr_D = d;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  function automatic vec_t mk(input logic ld, input logic [TW-1:0] th, input logic io,
                              input logic rdy, input logic v, input logic [TW-1:0] eth,
                              input logic [CW-1:0] ectl, input logic held,
                              input logic [RCW-1:0] eretry);
    vec_t r;
    r.ld        = ld;
    r.th        = th;
    r.io        = io;
    r.exp_rdy   = rdy;
    r.exp_v     = v;
    r.exp_th    = eth;
    r.exp_ctl   = ectl;
    r.exp_a     = held ? RAW'(2) : '0;
    r.exp_b     = held ? RAW'(3) : '0;
    r.exp_d     = held ? WAW'(4) : '0;
    r.exp_retry = eretry;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    bus.IO_ready = 1'b0;

    // ---- Reset: idle slots, issue_thread counts 0..7,0 ----
    do_reset();
    check("rst_valid", bus.issue_valid, 0);
    check("rst_bcancel", bus.branch_cancel, 1);
    check("rst_control", bus.control, 0);
    check("rst_thread", bus.issue_thread, 0);
    check("rst_retry", bus.retry_count, 0);
    check("rst_addr_a", bus.read_addr_A, 0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      check("idle_valid", bus.issue_valid, 0);
      check("idle_bcancel", bus.branch_cancel, 1);
      check("idle_control", bus.control, 0);
      check("idle_thread", bus.issue_thread, (n - 1) % TC);
    end

    // ---- Table: load thread 2, first result IO_ready=0, second 1 ----
    //          ld th io rdy v eth ctl held retry
    vecs[0]  = mk(1, 2, 1, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 2, 1, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 2, 1, 0, 1, 2, 5, 1, 0);
    vecs[3]  = mk(0, 2, 1, 0, 0, 3, 0, 1, 0);
    vecs[4]  = mk(0, 2, 1, 0, 0, 4, 0, 1, 0);
    vecs[5]  = mk(0, 2, 1, 0, 0, 5, 0, 1, 0);
    vecs[6]  = mk(0, 2, 0, 0, 0, 6, 0, 1, 1);
    vecs[7]  = mk(0, 2, 1, 0, 0, 7, 0, 1, 1);
    vecs[8]  = mk(0, 2, 1, 0, 0, 0, 0, 1, 1);
    vecs[9]  = mk(0, 2, 1, 0, 0, 1, 0, 1, 1);
    vecs[10] = mk(0, 2, 1, 0, 1, 2, 5, 1, 1);
    vecs[11] = mk(0, 2, 1, 0, 0, 3, 0, 1, 1);
    vecs[12] = mk(0, 2, 1, 0, 0, 4, 0, 1, 1);
    vecs[13] = mk(0, 2, 1, 0, 0, 5, 0, 1, 1);
    vecs[14] = mk(0, 2, 1, 0, 0, 6, 0, 1, 1);
    vecs[15] = mk(0, 2, 1, 1, 0, 7, 0, 1, 1);
    vecs[16] = mk(0, 2, 1, 1, 0, 0, 0, 1, 1);
    vecs[17] = mk(0, 2, 1, 1, 0, 1, 0, 1, 1);
    vecs[18] = mk(0, 2, 1, 1, 0, 2, 0, 1, 1);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      bus.in_valid        = vecs[i].ld;
      bus.in_thread       = vecs[i].th;
      bus.in_control      = CW'(5);
      bus.in_read_addr_A  = RAW'(2);
      bus.in_read_addr_B  = RAW'(3);
      bus.in_write_addr_D = WAW'(4);
      bus.IO_ready        = vecs[i].io;
      #1;
      check("tbl_in_ready", bus.in_ready, vecs[i].exp_rdy);
      tick();
      check("tbl_valid", bus.issue_valid, vecs[i].exp_v);
      check("tbl_bcancel", bus.branch_cancel, !vecs[i].exp_v);
      check("tbl_thread", bus.issue_thread, vecs[i].exp_th);
      check("tbl_control", bus.control, vecs[i].exp_ctl);
      check("tbl_split", bus.split, 0);
      check("tbl_addr_a", bus.read_addr_A, vecs[i].exp_a);
      check("tbl_addr_b", bus.read_addr_B, vecs[i].exp_b);
      check("tbl_addr_d", bus.write_addr_D, vecs[i].exp_d);
      check("tbl_retry", bus.retry_count, vecs[i].exp_retry);
    end
    idle_inputs();

    // ---- All threads loaded back-to-back, IO_ready always 1 ----
    bus.IO_ready = 1'b1;
    do_reset();
    for (int k = 0; k < TC; k++) begin
      drive_load(TW'(k), CW'((k % 2) * 20'h8_0000 + 20'h100 + k),
                 RAW'(10 + k), RAW'(20 + k), WAW'(30 + k));
      #1;
      check("all_in_ready", bus.in_ready, 1);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < TC; k++) begin
      tick();
      check("all_valid", bus.issue_valid, 1);
      check("all_thread", bus.issue_thread, k);
      check("all_control", bus.control, (k % 2) * 20'h8_0000 + 20'h100 + k);
      check("all_split", bus.split, k % 2);
      check("all_addr_a", bus.read_addr_A, 10 + k);
      check("all_addr_b", bus.read_addr_B, 20 + k);
      check("all_addr_d", bus.write_addr_D, 30 + k);
    end
    repeat (5) tick();
    for (int k = 0; k < TC; k++) begin
      bus.in_thread = TW'(k);
      #1;
      check("all_empty", bus.in_ready, 1);
    end
    check("all_retry", bus.retry_count, 0);

    // ---- Load conflict with a same-cycle retire of thread 5 ----
    bus.IO_ready = 1'b1;
    do_reset();
    drive_load(5, CW'(20'h0_0011), RAW'(1), RAW'(1), WAW'(1));
    tick();
    idle_inputs();
    while (cyc < 9) begin
      tick();
      if (cyc == 6) begin
        check("cfl_first_valid", bus.issue_valid, 1);
        check("cfl_first_ctl", bus.control, 20'h0_0011);
      end
    end
    drive_load(5, CW'(20'h0_0022), RAW'(2), RAW'(2), WAW'(2));
    #1;
    check("cfl_refused", bus.in_ready, 0);
    tick();
    drive_load(5, CW'(20'h8_0033), RAW'(3), RAW'(3), WAW'(3));
    #1;
    check("cfl_accept_rdy", bus.in_ready, 1);
    tick();
    idle_inputs();
    check("cfl_gap_valid", bus.issue_valid, 0);
    repeat (3) tick();
    check("cfl_valid", bus.issue_valid, 1);
    check("cfl_thread", bus.issue_thread, 5);
    check("cfl_control", bus.control, 20'h8_0033);
    check("cfl_split", bus.split, 1);
    check("cfl_addr_a", bus.read_addr_A, 3);
    check("cfl_retry", bus.retry_count, 0);

    // ---- Reset while threads 1 and 3 are in flight ----
    bus.IO_ready = 1'b0;
    do_reset();
    drive_load(1, CW'(20'h0_0101), RAW'(7), RAW'(7), WAW'(7));
    tick();
    drive_load(3, CW'(20'h0_0303), RAW'(9), RAW'(9), WAW'(9));
    tick();
    idle_inputs();
    repeat (2) tick();
    check("mid_pre_valid", bus.issue_valid, 1);
    check("mid_pre_thread", bus.issue_thread, 3);
    reset_n = 1'b0;
    #1;
    check("mid_valid", bus.issue_valid, 0);
    check("mid_bcancel", bus.branch_cancel, 1);
    check("mid_control", bus.control, 0);
    check("mid_addr_a", bus.read_addr_A, 0);
    check("mid_addr_b", bus.read_addr_B, 0);
    check("mid_addr_d", bus.write_addr_D, 0);
    check("mid_thread", bus.issue_thread, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("mid_no_issue", bus.issue_valid, 0);
    end
    check("mid_retry", bus.retry_count, 0);
    bus.in_thread = 1;
    #1;
    check("mid_empty_t1", bus.in_ready, 1);
    bus.in_thread = 3;
    #1;
    check("mid_empty_t3", bus.in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
